// File: rtl/tinycpu_loader.sv
// Program-load and run sequencer for the tiny stack CPU.
// Streams host words into CPU RAM, then releases CPU reset and times the run.
module tinycpu_loader #(
    parameter int AW = 12,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          abort,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    output logic          wr_ready,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_d,
    output logic          ram_load,
    output logic          cpu_rst_n,
    output logic          cpu_run,
    input  logic          cpu_halt,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count,
    output logic [CW-1:0] run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_DONE,
        S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   wc_q, wc_d;
    logic [CW-1:0] rc_q, rc_d;
    logic          rstn_q, rstn_d;
    logic          run_q, run_d;
    logic          restartable;
    logic          accept;

    assign restartable = (state_q == S_IDLE) || (state_q == S_DONE)
                      || (state_q == S_ERR);

    // An abort in the same cycle suppresses the RAM write.
    assign accept   = (state_q == S_LOAD) && wr_valid && !abort;
    assign wr_ready = (state_q == S_LOAD);
    assign ram_load = accept;
    assign ram_addr = addr_q;
    assign ram_d    = wr_data;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        rc_d    = rc_q;
        if (abort) begin
            state_d = S_IDLE;
        end else if (load_start && restartable) begin
            state_d = S_LOAD;
            addr_d  = '0;
            wc_d    = '0;
            rc_d    = '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (wr_valid) begin
                        addr_d = addr_q + AW'(1);
                        wc_d   = wc_q + (AW+1)'(1);
                        if (wr_last) begin
                            state_d = S_ARM;
                        end else if (addr_q == '1) begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_ARM: state_d = S_RUN;
                S_RUN: begin
                    if (rc_q != '1) begin
                        rc_d = rc_q + CW'(1);
                    end
                    // run_q marks the first RUN cycle, where halt is ignored.
                    if (cpu_halt && !run_q) begin
                        state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rstn_d = (state_d == S_ARM) || (state_d == S_RUN)
                 || (state_d == S_DONE);
    assign run_d  = (state_q == S_ARM) && (state_d == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wc_q    <= '0;
            rc_q    <= '0;
            rstn_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            rc_q    <= rc_d;
            rstn_q  <= rstn_d;
            run_q   <= run_d;
        end
    end

    assign cpu_rst_n  = rstn_q;
    assign cpu_run    = run_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_ARM)
                     || (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign word_count = wc_q;
    assign run_cycles = rc_q;

endmodule

// File: tb/tb_tinycpu_loader.sv
// Self-checking bench for tinycpu_loader: randomized loads/runs vs a
// behavioural model; a second instance with CW=4 exercises saturation.
module tb_tinycpu_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_start = 1'b0;
    logic        abort = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic        cpu_halt = 1'b0;

    logic        wr_ready, ram_load, cpu_rst_n, cpu_run, busy, done, err;
    logic [11:0] ram_addr;
    logic [15:0] ram_d;
    logic [12:0] word_count;
    logic [15:0] run_cycles;

    logic        wr_ready4, ram_load4, cpu_rst_n4, cpu_run4, busy4, done4, err4;
    logic [11:0] ram_addr4;
    logic [15:0] ram_d4;
    logic [12:0] word_count4;
    logic [3:0]  run_cycles4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [0:4095];
    logic [15:0] exp_q [$];

    tinycpu_loader #(.AW(12), .DW(16), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .abort(abort),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .ram_addr(ram_addr), .ram_d(ram_d),
        .ram_load(ram_load), .cpu_rst_n(cpu_rst_n), .cpu_run(cpu_run),
        .cpu_halt(cpu_halt), .busy(busy), .done(done), .err(err),
        .word_count(word_count), .run_cycles(run_cycles)
    );

    tinycpu_loader #(.AW(12), .DW(16), .CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .abort(abort),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready4), .ram_addr(ram_addr4), .ram_d(ram_d4),
        .ram_load(ram_load4), .cpu_rst_n(cpu_rst_n4), .cpu_run(cpu_run4),
        .cpu_halt(cpu_halt), .busy(busy4), .done(done4), .err(err4),
        .word_count(word_count4), .run_cycles(run_cycles4)
    );

    always #5 clk = ~clk;

    // Behavioural CPU RAM
    always @(posedge clk) begin
        if (ram_load) mem[ram_addr] <= ram_d;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_words(input int n, input bit last,
                               input int max_stall, input bit poke);
        for (int i = 0; i < n; i++) begin
            int stall;
            stall = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
            repeat (stall) begin
                wr_valid   = 1'b0;
                load_start = poke && ($urandom_range(0, 1) == 1);
                step();
            end
            load_start = 1'b0;
            wr_valid   = 1'b1;
            wr_data    = 16'($urandom);
            wr_last    = last && (i == n - 1);
            exp_q.push_back(wr_data);
            step();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] w;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, err, cpu_rst_n, cpu_run, wr_ready, ram_load} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0",
                     {busy, done, err, cpu_rst_n, cpu_run, wr_ready, ram_load});
        end
        n_cmp++;
        if (word_count !== 13'd0 || run_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", word_count, run_cycles);
        end
        step();
        rst_n = 1'b1;
        step();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w = 16'($urandom);
            wr_valid = 1'b1;
            wr_data  = w;
            step();
        end
        wr_valid = 1'b0;
        n_cmp++;
        if (word_count !== 13'd3) begin
            n_bad++;
            $display("FAIL midload_count got %0d want 3", word_count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, err, cpu_rst_n, cpu_run, wr_ready, ram_load} !== 7'b0
            || word_count !== 13'd0 || run_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset got flags %b wc %0d want 0",
                     {busy, done, err, cpu_rst_n, cpu_run, wr_ready, ram_load},
                     word_count);
        end
        step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (word_count !== 13'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset got wc %0d busy %b want 0 0", word_count, busy);
        end
    endtask

    task automatic test_load_run;
        logic [15:0] w [4];
        int r;
        int pulses;
        w[0] = 16'h1005; w[1] = 16'h1003; w[2] = 16'hF000; w[3] = 16'hE000;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        n_cmp++;
        if (wr_ready !== 1'b1 || busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL load_entry got rdy %b busy %b rstn %b want 1 1 0",
                     wr_ready, busy, cpu_rst_n);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                wr_valid = 1'b0;
                repeat (2) step();
            end
            wr_valid = 1'b1;
            wr_data  = w[i];
            wr_last  = (i == 3);
            step();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[i] !== w[i]) begin
                n_bad++;
                $display("FAIL ram[%0d] got %h want %h", i, mem[i], w[i]);
            end
        end
        n_cmp++;
        if (word_count !== 13'd4) begin
            n_bad++;
            $display("FAIL load_count got %0d want 4", word_count);
        end
        n_cmp++;
        if ({cpu_rst_n, cpu_run, busy, wr_ready} !== 4'b1010) begin
            n_bad++;
            $display("FAIL arm_cycle got %b want 1010",
                     {cpu_rst_n, cpu_run, busy, wr_ready});
        end
        step();
        n_cmp++;
        if (cpu_run !== 1'b1 || cpu_rst_n !== 1'b1) begin
            n_bad++;
            $display("FAIL run_pulse got run %b rstn %b want 1 1", cpu_run, cpu_rst_n);
        end
        pulses = 1;
        r = 0;
        while (!done && r < 100) begin
            cpu_halt = (r >= 10);
            step();
            r++;
            if (cpu_run) pulses++;
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || cpu_rst_n !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_done got done %b busy %b rstn %b want 1 0 1",
                     done, busy, cpu_rst_n);
        end
        n_cmp++;
        if (run_cycles !== 16'd11 || run_cycles4 !== 4'd11) begin
            n_bad++;
            $display("FAIL halt_cycles got %0d/%0d want 11/11", run_cycles, run_cycles4);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL run_pulses got %0d want 1", pulses);
        end
        cpu_halt = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (run_cycles !== 16'd11 || done !== 1'b1 || cpu_rst_n !== 1'b1) begin
            n_bad++;
            $display("FAIL done_frozen got rc %0d done %b want 11 1", run_cycles, done);
        end
    endtask

    task automatic test_random_programs;
        for (int it = 0; it < 4; it++) begin
            int n, d, r, exp_rc, exp_rc4, pulses;
            n = $urandom_range(1, 12);
            d = (it == 0) ? 0 : $urandom_range(1, 20);
            exp_rc  = ((d < 1) ? 1 : d) + 1;
            exp_rc4 = (exp_rc > 15) ? 15 : exp_rc;
            exp_q.delete();
            load_start = 1'b1;
            step();
            load_start = 1'b0;
            n_cmp++;
            if (word_count !== 13'd0 || run_cycles !== 16'd0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd%0d_restart got wc %0d rc %0d done %b want 0 0 0",
                         it, word_count, run_cycles, done);
            end
            drive_words(n, 1'b1, 2, 1'b1);
            n_cmp++;
            if (word_count !== 13'(n)) begin
                n_bad++;
                $display("FAIL rnd%0d_count got %0d want %0d", it, word_count, n);
            end
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (mem[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rnd%0d_ram[%0d] got %h want %h", it, i, mem[i], exp_q[i]);
                end
            end
            n_cmp++;
            if ({cpu_rst_n, cpu_run, busy} !== 3'b101) begin
                n_bad++;
                $display("FAIL rnd%0d_arm got %b want 101", it, {cpu_rst_n, cpu_run, busy});
            end
            step();
            pulses = cpu_run ? 1 : 0;
            r = 0;
            while (!done && r < 100) begin
                cpu_halt = (r >= d);
                step();
                r++;
                if (cpu_run) pulses++;
            end
            cpu_halt = 1'b0;
            n_cmp++;
            if (done !== 1'b1 || run_cycles !== 16'(exp_rc) || run_cycles4 !== 4'(exp_rc4)
                || pulses !== 1) begin
                n_bad++;
                $display("FAIL rnd%0d_run got done %b rc %0d/%0d pulses %0d want 1 %0d/%0d 1",
                         it, done, run_cycles, run_cycles4, pulses, exp_rc, exp_rc4);
            end
        end
    endtask

    task automatic test_overflow;
        logic [15:0] ov [4096];
        int bad_words;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'($urandom);
            wr_last  = 1'b0;
            ov[i]    = wr_data;
            #1;
            n_cmp++;
            if ({ram_load, wr_ready, ram_addr} !== {2'b11, 12'(i)}) begin
                n_bad++;
                $display("FAIL ovf_write%0d got ld %b rdy %b addr %h want 1 1 %h",
                         i, ram_load, wr_ready, ram_addr, 12'(i));
            end
            step();
        end
        wr_valid = 1'b0;
        n_cmp++;
        if ({err, busy, cpu_rst_n, wr_ready} !== 4'b1000 || word_count !== 13'd4096) begin
            n_bad++;
            $display("FAIL ovf_err got flags %b wc %0d want 1000 4096",
                     {err, busy, cpu_rst_n, wr_ready}, word_count);
        end
        bad_words = 0;
        for (int i = 0; i < 4096; i++) begin
            if (mem[i] !== ov[i]) bad_words++;
        end
        n_cmp++;
        if (bad_words !== 0) begin
            n_bad++;
            $display("FAIL ovf_ram got %0d bad words want 0", bad_words);
        end
        step();
        n_cmp++;
        if (err !== 1'b1 || cpu_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_hold got err %b rstn %b want 1 0", err, cpu_rst_n);
        end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        n_cmp++;
        if (err !== 1'b0 || word_count !== 13'd0 || wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_restart got err %b wc %0d rdy %b want 0 0 1",
                     err, word_count, wr_ready);
        end
        wr_valid = 1'b1;
        wr_data  = 16'($urandom);
        wr_last  = 1'b1;
        #1;
        n_cmp++;
        if (ram_addr !== 12'h000 || ram_load !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_addr0 got addr %h ld %b want 000 1", ram_addr, ram_load);
        end
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic test_abort_start;
        step();
        n_cmp++;
        if (cpu_run !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pre got run %b busy %b want 1 1", cpu_run, busy);
        end
        step();
        abort      = 1'b1;
        load_start = 1'b1;
        step();
        abort      = 1'b0;
        load_start = 1'b0;
        n_cmp++;
        if ({busy, done, err, cpu_rst_n, wr_ready, cpu_run} !== 6'b0
            || word_count !== 13'd1) begin
            n_bad++;
            $display("FAIL abort_idle got flags %b wc %0d want 0 1",
                     {busy, done, err, cpu_rst_n, wr_ready, cpu_run}, word_count);
        end
        wr_valid = 1'b1;
        wr_data  = 16'($urandom);
        #1;
        n_cmp++;
        if (ram_load !== 1'b0 || wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_write got ld %b rdy %b want 0 0", ram_load, wr_ready);
        end
        step();
        wr_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || word_count !== 13'd1) begin
            n_bad++;
            $display("FAIL idle_stay got busy %b wc %0d want 0 1", busy, word_count);
        end
    endtask

    task automatic test_saturation;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 16'($urandom);
        wr_last  = 1'b1;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        step();
        cpu_halt = 1'b0;
        repeat (40) step();
        n_cmp++;
        if (run_cycles4 !== 4'd15 || run_cycles !== 16'd40) begin
            n_bad++;
            $display("FAIL sat_count got %0d/%0d want 15/40", run_cycles4, run_cycles);
        end
        n_cmp++;
        if ({busy4, done4, cpu_rst_n4} !== 3'b101) begin
            n_bad++;
            $display("FAIL sat_running got %b want 101", {busy4, done4, cpu_rst_n4});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if ({busy4, done4, cpu_rst_n4, busy} !== 4'b0 || run_cycles4 !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_abort got %b rc %0d want 0000 15",
                     {busy4, done4, cpu_rst_n4, busy}, run_cycles4);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_run();
        test_random_programs();
        test_overflow();
        test_abort_start();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
